// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and constants for the two-port AXI-Stream frame arbiter.
//   - AXIS width constants (64-bit data, 8-bit keep)
//   - arbiter state enum (IFG state present only when ARB_IFG_EN is defined)
//   - packed beat payload used to mux the requester streams
package axis_frame_arbiter_pkg;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned AXIS_KEEP_W = 8;
    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned IFG_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
`ifdef ARB_IFG_EN
        , ST_IFG  = 2'd3
`endif
    } arb_state_e;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tuser;
        logic                   tlast;
    } axis_beat_t;

endpackage

// File: rtl/axis_rr_pick.sv
// Two-requester round-robin decision.
// Ports:
//   valid       - request pair {port1, port0}
//   last_grant  - index of the port that completed the previous frame
//   grant_idx   - port to grant (meaningful only when grant_valid = 1)
//   grant_valid - at least one requester is asking
module axis_rr_pick (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_idx,
    output logic       grant_valid
);

    // On contention the port that did not win last time takes the grant.
    always_comb begin
        grant_idx   = 1'b0;
        grant_valid = |valid;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Two-port AXI-Stream frame arbiter feeding the XGMII transmit path.
// A grant is held for a whole frame; round-robin between the two requesters
// on contention. The granted stream is passed through combinationally.
// Optional feature: define ARB_IFG_EN to insert IFG_CYCLES (1..15) idle
// cycles after each frame before returning to arbitration.
// Ports:
//   clock, aresetn           - clock, asynchronous active-low reset
//   saxis0_* / saxis1_*      - requester frame streams (tdata/tkeep/tuser/tlast/tvalid in, tready out)
//   maxis_*                  - arbitrated output stream (tready in)
//   frame_cnt0, frame_cnt1   - completed-frame counters per requester (wrap silently)
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   aresetn,

    input  logic [AXIS_DATA_W-1:0] saxis0_tdata,
    input  logic [AXIS_KEEP_W-1:0] saxis0_tkeep,
    input  logic                   saxis0_tuser,
    input  logic                   saxis0_tlast,
    input  logic                   saxis0_tvalid,
    output logic                   saxis0_tready,

    input  logic [AXIS_DATA_W-1:0] saxis1_tdata,
    input  logic [AXIS_KEEP_W-1:0] saxis1_tkeep,
    input  logic                   saxis1_tuser,
    input  logic                   saxis1_tlast,
    input  logic                   saxis1_tvalid,
    output logic                   saxis1_tready,

    output logic [AXIS_DATA_W-1:0] maxis_tdata,
    output logic [AXIS_KEEP_W-1:0] maxis_tkeep,
    output logic                   maxis_tuser,
    output logic                   maxis_tlast,
    output logic                   maxis_tvalid,
    input  logic                   maxis_tready,

    output logic [FRAME_CNT_W-1:0] frame_cnt0,
    output logic [FRAME_CNT_W-1:0] frame_cnt1
);

    // Elaboration-time guard on the gap length.
    if (IFG_CYCLES < 1 || IFG_CYCLES > 15) begin : g_bad_ifg
        $error("IFG_CYCLES must be in 1..15");
    end

`ifdef ARB_IFG_EN
    localparam arb_state_e ST_AFTER_FRAME = ST_IFG;
`else
    localparam arb_state_e ST_AFTER_FRAME = ST_IDLE;
`endif

    arb_state_e             state_q, state_d;
    logic                   last_grant_q;
    logic [FRAME_CNT_W-1:0] cnt0_q, cnt1_q;
    logic                   grant_idx, grant_valid;
    logic                   frame_end_c;
    axis_beat_t             s0_beat, s1_beat, m_beat;

    assign s0_beat = '{tdata: saxis0_tdata, tkeep: saxis0_tkeep, tuser: saxis0_tuser, tlast: saxis0_tlast};
    assign s1_beat = '{tdata: saxis1_tdata, tkeep: saxis1_tkeep, tuser: saxis1_tuser, tlast: saxis1_tlast};

    assign maxis_tdata = m_beat.tdata;
    assign maxis_tkeep = m_beat.tkeep;
    assign maxis_tuser = m_beat.tuser;
    assign maxis_tlast = m_beat.tlast;

    assign frame_cnt0 = cnt0_q;
    assign frame_cnt1 = cnt1_q;

    axis_rr_pick u_pick (
        .valid       ({saxis1_tvalid, saxis0_tvalid}),
        .last_grant  (last_grant_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

`ifdef ARB_IFG_EN
    logic [IFG_CNT_W-1:0] ifg_cnt_q;

    // Gap counter: loaded at frame end, counts the IFG cycles down to zero.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            ifg_cnt_q <= '0;
        end else if (frame_end_c) begin
            ifg_cnt_q <= IFG_CNT_W'(IFG_CYCLES - 1);
        end else if (state_q == ST_IFG && ifg_cnt_q != '0) begin
            ifg_cnt_q <= ifg_cnt_q - IFG_CNT_W'(1);
        end
    end
`endif

    // Next state and pass-through mux; only the granted port sees tready.
    always_comb begin
        state_d       = state_q;
        m_beat        = '0;
        maxis_tvalid  = 1'b0;
        saxis0_tready = 1'b0;
        saxis1_tready = 1'b0;
        frame_end_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = grant_idx ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0: begin
                m_beat        = s0_beat;
                maxis_tvalid  = saxis0_tvalid;
                saxis0_tready = maxis_tready;
                frame_end_c   = saxis0_tvalid & maxis_tready & saxis0_tlast;
                if (frame_end_c) begin
                    state_d = ST_AFTER_FRAME;
                end
            end
            ST_GRANT1: begin
                m_beat        = s1_beat;
                maxis_tvalid  = saxis1_tvalid;
                saxis1_tready = maxis_tready;
                frame_end_c   = saxis1_tvalid & maxis_tready & saxis1_tlast;
                if (frame_end_c) begin
                    state_d = ST_AFTER_FRAME;
                end
            end
`ifdef ARB_IFG_EN
            ST_IFG: begin
                if (ifg_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, round-robin history and frame counters.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q <= state_d;
            if (frame_end_c) begin
                last_grant_q <= (state_q == ST_GRANT1);
                if (state_q == ST_GRANT1) begin
                    cnt1_q <= cnt1_q + FRAME_CNT_W'(1);
                end else begin
                    cnt0_q <= cnt0_q + FRAME_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: queue-driven sources per port,
// captured output beats compared with hand-computed beat/cycle tables.
module tb_axis_frame_arbiter;

    logic        clock = 1'b0;
    logic        aresetn;
    logic [63:0] s0_tdata, s1_tdata, maxis_tdata;
    logic [7:0]  s0_tkeep, s1_tkeep, maxis_tkeep;
    logic        s0_tuser, s0_tlast, s0_tvalid, saxis0_tready;
    logic        s1_tuser, s1_tlast, s1_tvalid, saxis1_tready;
    logic        maxis_tuser, maxis_tlast, maxis_tvalid, maxis_tready;
    logic [31:0] frame_cnt0, frame_cnt1;

    always #5 clock = ~clock;

    axis_frame_arbiter #(.IFG_CYCLES(3)) dut (
        .clock         (clock),
        .aresetn       (aresetn),
        .saxis0_tdata  (s0_tdata),
        .saxis0_tkeep  (s0_tkeep),
        .saxis0_tuser  (s0_tuser),
        .saxis0_tlast  (s0_tlast),
        .saxis0_tvalid (s0_tvalid),
        .saxis0_tready (saxis0_tready),
        .saxis1_tdata  (s1_tdata),
        .saxis1_tkeep  (s1_tkeep),
        .saxis1_tuser  (s1_tuser),
        .saxis1_tlast  (s1_tlast),
        .saxis1_tvalid (s1_tvalid),
        .saxis1_tready (saxis1_tready),
        .maxis_tdata   (maxis_tdata),
        .maxis_tkeep   (maxis_tkeep),
        .maxis_tuser   (maxis_tuser),
        .maxis_tlast   (maxis_tlast),
        .maxis_tvalid  (maxis_tvalid),
        .maxis_tready  (maxis_tready),
        .frame_cnt0    (frame_cnt0),
        .frame_cnt1    (frame_cnt1)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        user;
        logic        bubble;
    } src_t;

    src_t        q0[$], q1[$];
    logic        rdy_pat[$];
    logic [63:0] cap_d[$], exp_d[$];
    logic [7:0]  cap_k[$];
    logic        cap_l[$], cap_u[$], exp_l[$], exp_u[$];
    int          cap_c[$], exp_c[$];
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          both_rdy = 0;
    logic        s1_rdy_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int port, input logic [63:0] d, input logic last,
                        input logic user, input logic bubble);
        src_t e;
        e = '{data: d, last: last, user: user, bubble: bubble};
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic expect_beat(input logic [63:0] d, input int c, input logic last, input logic user);
        exp_d.push_back(d);
        exp_c.push_back(c);
        exp_l.push_back(last);
        exp_u.push_back(user);
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_u.delete(); cap_c.delete();
        exp_d.delete(); exp_l.delete(); exp_u.delete(); exp_c.delete();
    endtask

    // Drive each source from the head of its queue; tkeep tracks the data low byte.
    task automatic present();
        s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tuser = 1'b0; s0_tdata = '0; s0_tkeep = '0;
        s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tuser = 1'b0; s1_tdata = '0; s1_tkeep = '0;
        if (q0.size() != 0) begin
            s0_tdata = q0[0].data; s0_tkeep = q0[0].data[7:0];
            s0_tlast = q0[0].last; s0_tuser = q0[0].user; s0_tvalid = !q0[0].bubble;
        end
        if (q1.size() != 0) begin
            s1_tdata = q1[0].data; s1_tkeep = q1[0].data[7:0];
            s1_tlast = q1[0].last; s1_tuser = q1[0].user; s1_tvalid = !q1[0].bubble;
        end
        maxis_tready = (rdy_pat.size() != 0) ? rdy_pat[0] : 1'b1;
    endtask

    // One clock: sample just after the falling edge, advance sources at the next one.
    task automatic step();
        logic hs0, hs1;
        #1;
        hs0 = s0_tvalid && saxis0_tready;
        hs1 = s1_tvalid && saxis1_tready;
        if (saxis0_tready && saxis1_tready) both_rdy++;
        if (saxis1_tready) s1_rdy_seen = 1'b1;
        if (maxis_tvalid && maxis_tready) begin
            cap_d.push_back(maxis_tdata);
            cap_k.push_back(maxis_tkeep);
            cap_l.push_back(maxis_tlast);
            cap_u.push_back(maxis_tuser);
            cap_c.push_back(cyc);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (q0.size() != 0 && (hs0 || q0[0].bubble)) void'(q0.pop_front());
        if (q1.size() != 0 && (hs1 || q1[0].bubble)) void'(q1.pop_front());
        if (rdy_pat.size() != 0) void'(rdy_pat.pop_front());
        present();
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout_left"}, 64'(q0.size() + q1.size()), 64'd0);
        q0.delete();
        q1.delete();
        present();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic verify_beats(input string tag);
        check({tag, "_nbeats"}, 64'(cap_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), cap_d[i], exp_d[i]);
            check($sformatf("%s_keep%0d", tag, i), 64'(cap_k[i]), 64'(exp_d[i][7:0]));
            check($sformatf("%s_cyc%0d",  tag, i), 64'(cap_c[i]), 64'(exp_c[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(cap_l[i]), 64'(exp_l[i]));
            check($sformatf("%s_user%0d", tag, i), 64'(cap_u[i]), 64'(exp_u[i]));
        end
    endtask

    // Hold reset across a falling edge; sources are cleared, caller fills queues then calls release_reset.
    task automatic hold_reset();
        @(negedge clock);
        aresetn = 1'b0;
        q0.delete(); q1.delete(); rdy_pat.delete();
        clear_caps();
        present();
    endtask

    task automatic release_reset();
        present();
        @(negedge clock);
        aresetn = 1'b1;
        cyc = 1;
        s1_rdy_seen = 1'b0;
        both_rdy = 0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        aresetn = 1'b0;
        present();

        // Reset state
        #2;
        check("rst_tready0", 64'(saxis0_tready), 64'd0);
        check("rst_tready1", 64'(saxis1_tready), 64'd0);
        check("rst_mvalid",  64'(maxis_tvalid),  64'd0);
        check("rst_mlast",   64'(maxis_tlast),   64'd0);
        check("rst_muser",   64'(maxis_tuser),   64'd0);
        check("rst_cnt0",    64'(frame_cnt0),    64'd0);
        check("rst_cnt1",    64'(frame_cnt1),    64'd0);

        // Both ports valid at release: port 0, port 1, port 0 again, whole frames
        hold_reset();
        push(0, 64'hA0, 1'b0, 1'b0, 1'b0); push(0, 64'hA1, 1'b1, 1'b0, 1'b0);
        push(0, 64'hA2, 1'b0, 1'b0, 1'b0); push(0, 64'hA3, 1'b1, 1'b0, 1'b0);
        push(1, 64'hB0, 1'b0, 1'b0, 1'b0); push(1, 64'hB1, 1'b1, 1'b0, 1'b0);
        release_reset();
        run("rr", 40);
        expect_beat(64'hA0, 2, 1'b0, 1'b0); expect_beat(64'hA1, 3, 1'b1, 1'b0);
        expect_beat(64'hB0, 5, 1'b0, 1'b0); expect_beat(64'hB1, 6, 1'b1, 1'b0);
        expect_beat(64'hA2, 8, 1'b0, 1'b0); expect_beat(64'hA3, 9, 1'b1, 1'b0);
        verify_beats("rr");
        check("rr_cnt0", 64'(frame_cnt0), 64'd2);
        check("rr_cnt1", 64'(frame_cnt1), 64'd1);
        check("rr_both_ready", 64'(both_rdy), 64'd0);

        // Port 0 alone, 3-word frame, one-cycle arbitration latency
        hold_reset();
        push(0, 64'h1111_0000_0000_00D0, 1'b0, 1'b0, 1'b0);
        push(0, 64'h1111_0000_0000_00D1, 1'b0, 1'b0, 1'b0);
        push(0, 64'h1111_0000_0000_00D2, 1'b1, 1'b0, 1'b0);
        release_reset();
        #1;
        check("p0_idle_tready0", 64'(saxis0_tready), 64'd0);
        check("p0_idle_mvalid",  64'(maxis_tvalid),  64'd0);
        run("p0", 40);
        expect_beat(64'h1111_0000_0000_00D0, 2, 1'b0, 1'b0);
        expect_beat(64'h1111_0000_0000_00D1, 3, 1'b0, 1'b0);
        expect_beat(64'h1111_0000_0000_00D2, 4, 1'b1, 1'b0);
        verify_beats("p0");
        check("p0_cnt0", 64'(frame_cnt0), 64'd1);
        check("p0_cnt1", 64'(frame_cnt1), 64'd0);
        check("p0_tready1_seen", 64'(s1_rdy_seen), 64'd0);

        // Port 1, 4-word tuser frame under alternating downstream ready
        hold_reset();
        for (int i = 0; i < 4; i++) push(1, 64'hE0 + 64'(i), (i == 3), 1'b1, 1'b0);
        pat = 8'b1010_1011;
        for (int i = 0; i < 8; i++) rdy_pat.push_back(pat[i]);
        release_reset();
        run("bp", 40);
        for (int i = 0; i < 4; i++) expect_beat(64'hE0 + 64'(i), 2 + 2 * i, (i == 3), 1'b1);
        verify_beats("bp");
        check("bp_cnt1", 64'(frame_cnt1), 64'd1);
        check("bp_cnt0", 64'(frame_cnt0), 64'd0);

        // Port 0 drops valid mid-frame while port 1 waits: grant is held
        hold_reset();
        push(0, 64'hC0, 1'b0, 1'b0, 1'b0);
        push(0, 64'h0,  1'b0, 1'b0, 1'b1);
        push(0, 64'hC1, 1'b1, 1'b0, 1'b0);
        push(1, 64'hF0, 1'b1, 1'b0, 1'b0);
        release_reset();
        run("hold", 40);
        expect_beat(64'hC0, 2, 1'b0, 1'b0);
        expect_beat(64'hC1, 4, 1'b1, 1'b0);
        expect_beat(64'hF0, 6, 1'b1, 1'b0);
        verify_beats("hold");
        check("hold_cnt0", 64'(frame_cnt0), 64'd1);
        check("hold_cnt1", 64'(frame_cnt1), 64'd1);
        check("hold_both_ready", 64'(both_rdy), 64'd0);

        // Back-to-back single-word frames from port 1 (gap depends on ARB_IFG_EN)
        hold_reset();
        push(1, 64'h51, 1'b1, 1'b0, 1'b0);
        push(1, 64'h52, 1'b1, 1'b0, 1'b0);
        release_reset();
        run("sw", 40);
        expect_beat(64'h51, 2, 1'b1, 1'b0);
`ifdef ARB_IFG_EN
        expect_beat(64'h52, 7, 1'b1, 1'b0);
`else
        expect_beat(64'h52, 4, 1'b1, 1'b0);
`endif
        verify_beats("sw");
        check("sw_cnt1", 64'(frame_cnt1), 64'd2);

        // Reset pulsed during word 2 of a port 0 frame
        clear_caps();
        cyc = 1;
        push(0, 64'h70, 1'b0, 1'b0, 1'b0);
        push(0, 64'h71, 1'b0, 1'b0, 1'b0);
        push(0, 64'h72, 1'b1, 1'b0, 1'b0);
        present();
        step();
        step();
        #2;
        check("mid_pre_mvalid", 64'(maxis_tvalid), 64'd1);
        check("mid_pre_data", maxis_tdata, 64'h71);
        aresetn = 1'b0;
        #1;
        check("mid_mvalid",  64'(maxis_tvalid),  64'd0);
        check("mid_tready0", 64'(saxis0_tready), 64'd0);
        check("mid_mlast",   64'(maxis_tlast),   64'd0);
        check("mid_cnt0",    64'(frame_cnt0),    64'd0);
        check("mid_cnt1",    64'(frame_cnt1),    64'd0);
        check("mid_beats_before", 64'(cap_d.size()), 64'd1);
        q0.delete();
        clear_caps();
        push(1, 64'h90, 1'b1, 1'b0, 1'b0);
        release_reset();
        run("post", 40);
        expect_beat(64'h90, 2, 1'b1, 1'b0);
        verify_beats("post");
        check("post_cnt1", 64'(frame_cnt1), 64'd1);
        check("post_cnt0", 64'(frame_cnt0), 64'd0);

        // Counter wrap from all-ones
        clear_caps();
        force dut.cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0_q;
        check("wrap_pre", 64'(frame_cnt0), 64'hFFFF_FFFF);
        cyc = 1;
        push(0, 64'hBEEF, 1'b1, 1'b0, 1'b0);
        present();
        run("wrap", 40);
        expect_beat(64'hBEEF, 2, 1'b1, 1'b0);
        verify_beats("wrap");
        check("wrap_cnt0", 64'(frame_cnt0), 64'd0);
        check("wrap_cnt1", 64'(frame_cnt1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
